cam_capture_win: RTL

Parametrised DVP camera capture front end for the image pipeline, sitting between the sensor pins (vsync/href/din) and the gray/filter/bin/sobel chain. It assembles 1 or 2 sensor bytes per pixel and crops a parameterised window out of the active frame. It emits the window as a vld/sop/eop pixel stream. It flags malformed lines and truncated frames, and it gates capture per frame with en_capture.

---
 rtl/cam_capture_win_if.sv | 13 +
 rtl/cam_capture_win.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cam_capture_win_if.sv
// Pixel stream produced by the camera capture front end: data plus valid,
// start-of-window and end-of-window markers, with no backpressure.
interface cam_capture_win_if #(
    parameter int DW = 16
);
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_sop;
    logic          dout_eop;

    modport master (output dout, dout_vld, dout_sop, dout_eop);
    modport slave  (input  dout, dout_vld, dout_sop, dout_eop);
endinterface

// File: rtl/cam_capture_win.sv
// DVP capture front end: registers the sensor pins, packs BPP bytes per pixel,
// crops a fixed window from each enabled frame and flags malformed lines/frames.
module cam_capture_win #(
    parameter int DW_IN    = 8,
    parameter int BPP      = 2,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_START  = 0,
    parameter int Y_START  = 0,
    parameter int WIN_W    = 640,
    parameter int WIN_H    = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_capture,
    input  logic             vsync,
    input  logic             href,
    input  logic [DW_IN-1:0] din,
    cam_capture_win_if.master pix,
    output logic             frame_done,
    output logic             line_err,
    output logic             frame_err
);
    localparam int DW_OUT = DW_IN * BPP;
    localparam int XW     = $clog2(H_ACTIVE + 1);
    localparam int YW     = $clog2(V_ACTIVE + 1);

    typedef enum logic {IDLE, CAPTURE} state_t;
    state_t state, state_nxt;

    logic              vsync_r, vsync_rr, href_r, href_rr;
    logic [DW_IN-1:0]  din_r;
    logic              phase, ovf;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic              vsync_rise, href_fall, start, abort, last_line, in_win;
    logic [31:0]       x_off, y_off;
    logic [DW_OUT-1:0] pix_word;

    assign vsync_rise = vsync_r & ~vsync_rr;
    assign href_fall  = ~href_r & href_rr;
    assign last_line  = (32'(y_cnt) + 32'd1) == 32'(V_ACTIVE);

    // Offsets wrap to huge values below the origin, so one unsigned compare covers both bounds.
    assign x_off  = 32'(x_cnt) - 32'(X_START);
    assign y_off  = 32'(y_cnt) - 32'(Y_START);
    assign in_win = (x_off < 32'(WIN_W)) && (y_off < 32'(WIN_H));

    generate
        if (BPP == 1) begin : g_bpp1
            assign pix_word = din_r;
        end else begin : g_bpp2
            logic [DW_IN-1:0] hi_byte;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    hi_byte <= '0;
                else if (state == CAPTURE && href_r && !phase)
                    hi_byte <= din_r;
            end
            assign pix_word = {hi_byte, din_r};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_rise && en_capture) begin
                    state_nxt = CAPTURE;
                    start     = 1'b1;
                end
            end
            CAPTURE: begin
                if (vsync_rise) begin
                    abort = 1'b1;
                    start = en_capture;
                    if (!en_capture)
                        state_nxt = IDLE;
                end else if (href_fall && x_cnt != '0 && last_line) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_r      <= 1'b0;
            vsync_rr     <= 1'b0;
            href_r       <= 1'b0;
            href_rr      <= 1'b0;
            din_r        <= '0;
            phase        <= 1'b0;
            ovf          <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            pix.dout     <= '0;
            pix.dout_vld <= 1'b0;
            pix.dout_sop <= 1'b0;
            pix.dout_eop <= 1'b0;
            frame_done   <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            vsync_r      <= vsync;
            vsync_rr     <= vsync_r;
            href_r       <= href;
            href_rr      <= href_r;
            din_r        <= din;
            pix.dout_vld <= 1'b0;
            pix.dout_sop <= 1'b0;
            pix.dout_eop <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= abort;
            frame_done   <= pix.dout_eop;

            if (start) begin
                x_cnt <= '0;
                y_cnt <= '0;
                phase <= 1'b0;
                ovf   <= 1'b0;
            end else if (state == CAPTURE && !vsync_rise) begin
                if (href_fall) begin
                    if (x_cnt != '0)
                        y_cnt <= y_cnt + YW'(1);
                    x_cnt    <= '0;
                    phase    <= 1'b0;
                    ovf      <= 1'b0;
                    line_err <= (x_cnt != XW'(H_ACTIVE)) || phase || ovf;
                end else if (!href_r) begin
                    phase <= 1'b0;
                end else if (BPP == 2 && !phase) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    // Pixels beyond a full line are dropped but remembered for line_err.
                    if (x_cnt == XW'(H_ACTIVE)) begin
                        ovf <= 1'b1;
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                        if (in_win) begin
                            pix.dout     <= pix_word;
                            pix.dout_vld <= 1'b1;
                            pix.dout_sop <= (x_cnt == XW'(X_START)) && (y_cnt == YW'(Y_START));
                            pix.dout_eop <= (x_cnt == XW'(X_START + WIN_W - 1)) &&
                                            (y_cnt == YW'(Y_START + WIN_H - 1));
                        end
                    end
                end
            end
        end
    end
endmodule
